alu_slice_sequencer: RTL and testbench
======================================

# alu_slice_sequencer

Multi-cycle, parametrised successor to the combinational slice interconnect. It processes a W = N_A*S-bit operand pair N_P slices per cycle, with the inter-slice state (carry, shift bit, popcount accumulator, compare verdict) held in registers between passes. A valid/ready handshake sits on each side. The block sits between the AXI register front-end and the result writeback.

## Interface
- S, default 4: slice width in bits.
- N_A, default 8: logical slices per operand; W = N_A*S.
- N_P, default 2: slices processed per cycle. N_A must be a multiple of N_P. P = N_A/N_P passes.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  block idle and able to accept.
- op  in  3  000 ADD, 001 RSHIFT, 010 POPCOUNT, 011 COMPARE, 100 SUB. Remaining codes are illegal.
- a, b  in  W  operands; b is ignored for RSHIFT and POPCOUNT.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- res  out  W  result word.
- cmp  out  2  compare result: 00 EQ, 01 LT, 10 GT. Zero for non-compare ops.
- carry  out  1  ADD carry-out, SUB no-borrow, or the bit shifted out by RSHIFT. Zero otherwise.
- err  out  1  illegal op.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch op/a/b, clear the accumulators, and go to RUN. For an illegal op, go to DONE directly.
  - RUN: process one chunk (N_P*S bits) per cycle; chunk index register k.
  - DONE: out_valid=1. Hold all outputs until out_ready, then go to IDLE.
- ADD: chunks LSB-first, k = 0..P-1. The carry register starts at 0 and carry-out of chunk k feeds chunk k+1. carry = final carry.
- SUB: a + ~b with initial carry 1. carry=1 means a >= b (unsigned).
- RSHIFT: logical shift right by one, LSB-first. Chunk k takes a[(k+1)*N_P*S] as its fill bit; the top chunk fills 0. carry = a[0].
- POPCOUNT: per-chunk popcount is added into an accumulator of clog2(W+1) bits. res = accumulator, zero-extended.
- COMPARE: unsigned, chunks MSB-first.
  - The first unequal chunk sets cmp and exits to DONE immediately.
  - If all chunks are equal, cmp=00 after P passes.
- Illegal op: res=0, cmp=00, carry=0, err=1.
- Reset asserted at any time (including mid-RUN or DONE):
  - state goes to IDLE and the in-flight request is discarded with no out_valid;
  - all outputs go to 0, including in_ready.

## Timing
- Reset values: in_ready=0, out_valid=0, res=0, cmp=00, carry=0, err=0. in_ready rises on the first clk edge after rst_n deasserts.
- Accept occurs on the edge where in_valid && in_ready.
- Latency from accept to out_valid:
  - ADD/SUB/RSHIFT/POPCOUNT: P+1 cycles.
  - COMPARE: j+2 cycles, where j is the MSB-first index of the first unequal chunk (P+1 if all chunks are equal).
  - Illegal op: 1 cycle.
- in_ready=0 throughout RUN and DONE; there is no overlap of requests.
- Release occurs on the edge where out_valid && out_ready. in_ready=1 the following cycle.
- res/cmp/carry/err are registered, stable while out_valid=1, and keep their last value after release.
- An out_ready held high in advance completes the handshake in the first DONE cycle.

## Configuration
- SLICE_SEQ_SUB_EN:
  - Defined: op 100 performs SUB as above.
  - Undefined: op 100 is illegal (err=1). The complement logic and the carry-init mux are not synthesised.

## Structure
- Package slice_seq_pkg holds:
  - op code localparams;
  - cmp codes (EQ/LT/GT);
  - the FSM state enum (IDLE/RUN/DONE).
- Sub-module slice_chunk_alu is a combinational N_P*S-bit chunk datapath. It has:
  - inputs: op, chunk of a, chunk of b, carry-in, fill bit;
  - outputs: chunk result, carry-out, chunk popcount, chunk compare.
- The top level owns the FSM, chunk index, result shift/insert, accumulators and handshake.

## Test plan
Defaults throughout: S=4, N_A=8, N_P=2, so W=32 and P=4.
- ADD a=0xFFFFFFFF, b=0x00000001: res=0x00000000, carry=1, out_valid 5 cycles after accept.
- RSHIFT a=0x80000001: res=0x40000000, carry=1.
- POPCOUNT a=0xF0F0000F: res=0x0000000C, 5-cycle latency.
- COMPARE:
  - a=0x80000000, b=0x7FFFFFFF: cmp=10 with out_valid 2 cycles after accept.
  - a=b=0x12345678: cmp=00 at 5 cycles.
  - a=0x00000001, b=0x00000002: cmp=01.
- SUB (macro defined) a=5, b=7: res=0xFFFFFFFE, carry=0.
  - Macro undefined: op 100 gives err=1, res=0, 1-cycle latency.
  - Op 111 gives err=1 regardless of the macro.
- Back-pressure and reset:
  - Hold out_ready=0 for 3 DONE cycles: outputs stay stable and in_ready stays 0; release then gives in_ready=1 the next cycle.
  - Drop rst_n during RUN: all outputs 0 immediately with no out_valid. After deassert, a new ADD 3+4 gives 7.

Source files
------------

// File: rtl/slice_seq_pkg.sv
// Shared op codes, compare verdicts and sequencer state encoding for the ALU slice sequencer.
package slice_seq_pkg;

   localparam logic [2:0] OP_ADD      = 3'b000;
   localparam logic [2:0] OP_RSHIFT   = 3'b001;
   localparam logic [2:0] OP_POPCOUNT = 3'b010;
   localparam logic [2:0] OP_COMPARE  = 3'b011;
   localparam logic [2:0] OP_SUB      = 3'b100;

   typedef enum logic [1:0] {
      CMP_EQ = 2'b00,
      CMP_LT = 2'b01,
      CMP_GT = 2'b10
   } cmp_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/alu_slice_sequencer_if.sv
// Request/result handshake bundle between the register front-end and the slice sequencer.
interface alu_slice_sequencer_if #(parameter int W = 32);
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] res;
   logic [1:0]   cmp;
   logic         carry;
   logic         err;

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, res, cmp, carry, err
   );

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, res, cmp, carry, err
   );
endinterface

// File: rtl/slice_chunk_alu.sv
// Combinational datapath for one chunk of N_P slices. SUB support depends on SLICE_SEQ_SUB_EN.
module slice_chunk_alu
   import slice_seq_pkg::*;
#(
   parameter int CW  = 8,
   parameter int CPW = $clog2(CW + 1)
) (
   input  logic [2:0]    op,
   input  logic [CW-1:0] ca,
   input  logic [CW-1:0] cb,
   input  logic          cin,
   input  logic          fill,
   output logic [CW-1:0] y,
   output logic          cout,
   output logic [CPW-1:0] pc,
   output cmp_t          cmpc
);

   logic [CW:0] sum;

   always_comb begin
      sum = '0;
      case (op)
         OP_ADD:    sum = {1'b0, ca} + {1'b0, cb} + {{CW{1'b0}}, cin};
`ifdef SLICE_SEQ_SUB_EN
         OP_SUB:    sum = {1'b0, ca} + {1'b0, ~cb} + {{CW{1'b0}}, cin};
`endif
         // top bit of sum carries the bit shifted out of this chunk
         OP_RSHIFT: sum = {ca[0], fill, ca[CW-1:1]};
         default:   sum = '0;
      endcase
      y    = sum[CW-1:0];
      cout = sum[CW];
   end

   always_comb begin
      pc = '0;
      for (int i = 0; i < CW; i++) pc = pc + CPW'(ca[i]);
   end

   always_comb begin
      if (ca == cb)     cmpc = CMP_EQ;
      else if (ca < cb) cmpc = CMP_LT;
      else              cmpc = CMP_GT;
   end

endmodule

// File: rtl/alu_slice_sequencer.sv
// Multi-pass ALU over W = N_A*S bits, N_P slices per cycle. Optional SUB via SLICE_SEQ_SUB_EN.
module alu_slice_sequencer
   import slice_seq_pkg::*;
#(
   parameter int S   = 4,
   parameter int N_A = 8,
   parameter int N_P = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   alu_slice_sequencer_if.slave bus
);

   // state | meaning
   // IDLE  | in_ready high, waiting for a request
   // RUN   | one chunk per cycle, chunk index k
   // DONE  | out_valid high, result held until out_ready

   localparam int W   = N_A * S;
   localparam int CW  = N_P * S;
   localparam int P   = N_A / N_P;
   localparam int KW  = (P > 1) ? $clog2(P) : 1;
   localparam int PCW = $clog2(W + 1);
   localparam int CPW = $clog2(CW + 1);

   state_t         state;
   logic [KW-1:0]  k;
   logic [2:0]     op_r;
   logic [W-1:0]   a_r, b_r, res_acc;
   logic           cy_r;
   logic [PCW-1:0] pc_r;

   logic           in_ready_r, out_valid_r, carry_r, err_r;
   logic [W-1:0]   res_r;
   cmp_t           cmp_r;

   logic           is_cmp, last, legal, fill;
   logic [CW-1:0]  ca, cb, y_c;
   logic           cout_c;
   logic [CPW-1:0] pc_c;
   cmp_t           cmp_c;
   logic [W-1:0]   res_next;
   logic [PCW-1:0] pc_next;

   // compare walks chunks MSB-first, everything else LSB-first
   assign is_cmp = (op_r == OP_COMPARE);
   assign ca     = is_cmp ? a_r[W-1 -: CW] : a_r[CW-1:0];
   assign cb     = is_cmp ? b_r[W-1 -: CW] : b_r[CW-1:0];
   assign last   = (k == KW'(P - 1));

   generate
      if (N_A > N_P) begin : g_fill
         assign fill = a_r[CW];
      end else begin : g_nofill
         assign fill = 1'b0;
      end
   endgenerate

`ifdef SLICE_SEQ_SUB_EN
   assign legal = (bus.op <= OP_COMPARE) || (bus.op == OP_SUB);
`else
   assign legal = (bus.op <= OP_COMPARE);
`endif

   slice_chunk_alu #(.CW(CW), .CPW(CPW)) u_chunk (
      .op   (op_r),
      .ca   (ca),
      .cb   (cb),
      .cin  (cy_r),
      .fill (fill),
      .y    (y_c),
      .cout (cout_c),
      .pc   (pc_c),
      .cmpc (cmp_c)
   );

   assign res_next = W'({y_c, res_acc} >> CW);
   assign pc_next  = pc_r + PCW'(pc_c);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         k           <= '0;
         op_r        <= '0;
         a_r         <= '0;
         b_r         <= '0;
         res_acc     <= '0;
         cy_r        <= 1'b0;
         pc_r        <= '0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         res_r       <= '0;
         cmp_r       <= CMP_EQ;
         carry_r     <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               in_ready_r <= 1'b1;
               if (bus.in_valid && in_ready_r) begin
                  in_ready_r <= 1'b0;
                  op_r       <= bus.op;
                  a_r        <= bus.a;
                  b_r        <= bus.b;
                  k          <= '0;
                  res_acc    <= '0;
                  pc_r       <= '0;
`ifdef SLICE_SEQ_SUB_EN
                  cy_r       <= (bus.op == OP_SUB) ? 1'b1 : ((bus.op == OP_RSHIFT) && bus.a[0]);
`else
                  cy_r       <= (bus.op == OP_RSHIFT) && bus.a[0];
`endif
                  if (legal) begin
                     state <= ST_RUN;
                  end else begin
                     state       <= ST_DONE;
                     out_valid_r <= 1'b1;
                     res_r       <= '0;
                     cmp_r       <= CMP_EQ;
                     carry_r     <= 1'b0;
                     err_r       <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               k       <= k + KW'(1);
               res_acc <= res_next;
               pc_r    <= pc_next;
               if (is_cmp) begin
                  a_r <= a_r << CW;
                  b_r <= b_r << CW;
               end else begin
                  a_r <= a_r >> CW;
                  b_r <= b_r >> CW;
               end
               if (op_r == OP_ADD || op_r == OP_SUB) cy_r <= cout_c;
               if (last || (is_cmp && cmp_c != CMP_EQ)) begin
                  state       <= ST_DONE;
                  out_valid_r <= 1'b1;
                  err_r       <= 1'b0;
                  res_r       <= '0;
                  cmp_r       <= CMP_EQ;
                  carry_r     <= 1'b0;
                  case (op_r)
                     OP_ADD, OP_SUB: begin
                        res_r   <= res_next;
                        carry_r <= cout_c;
                     end
                     OP_RSHIFT: begin
                        res_r   <= res_next;
                        carry_r <= cy_r;
                     end
                     OP_POPCOUNT: res_r <= W'(pc_next);
                     OP_COMPARE:  cmp_r <= cmp_c;
                     default:     res_r <= '0;
                  endcase
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.res       = res_r;
   assign bus.cmp       = cmp_r;
   assign bus.carry     = carry_r;
   assign bus.err       = err_r;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Directed bench for alu_slice_sequencer with a whole-word reference model and result scoreboard.
module tb_alu_slice_sequencer;

   typedef struct {
      logic [31:0] res;
      logic [1:0]  cmp;
      logic        carry;
      logic        err;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   alu_slice_sequencer_if #(.W(32)) bus ();

   alu_slice_sequencer #(.S(4), .N_A(8), .N_P(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [32:0] s;
      logic [7:0] ca, cb;
      bit found;
      e.res = '0; e.cmp = 2'b00; e.carry = 1'b0; e.err = 1'b0; e.lat = 5;
      case (op)
         3'b000: begin s = {1'b0, a} + {1'b0, b}; e.res = s[31:0]; e.carry = s[32]; end
         3'b001: begin e.res = a >> 1; e.carry = a[0]; end
         3'b010: e.res = 32'($countones(a));
         3'b011: begin
            e.cmp = (a == b) ? 2'b00 : ((a < b) ? 2'b01 : 2'b10);
            found = 1'b0;
            for (int j = 0; j < 4; j++) begin
               ca = a[31 - 8*j -: 8];
               cb = b[31 - 8*j -: 8];
               if (!found && ca != cb) begin found = 1'b1; e.lat = j + 2; end
            end
         end
`ifdef SLICE_SEQ_SUB_EN
         3'b100: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; e.res = s[31:0]; e.carry = s[32]; end
`endif
         default: begin e.err = 1'b1; e.lat = 1; end
      endcase
      return e;
   endfunction

   task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int hold, input bit early);
      exp_t e;
      int n, lat;
      n = 0;
      while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
      chk("in_ready_before_req", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      bus.out_ready = early;
      sb.push_back(model(op, a, b));
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 40) begin @(negedge clk); lat++; end
      chk("out_valid_timeout", 64'(bus.out_valid), 64'd1);
      e = sb.pop_front();
      chk("latency", 64'(lat), 64'(e.lat));
      chk("res", 64'(bus.res), 64'(e.res));
      chk("cmp", 64'(bus.cmp), 64'(e.cmp));
      chk("carry", 64'(bus.carry), 64'(e.carry));
      chk("err", 64'(bus.err), 64'(e.err));
      chk("in_ready_in_done", 64'(bus.in_ready), 64'd0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
         chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
         chk("hold_res", 64'(bus.res), 64'(e.res));
         chk("hold_carry", 64'(bus.carry), 64'(e.carry));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("released_out_valid", 64'(bus.out_valid), 64'd0);
      chk("released_in_ready", 64'(bus.in_ready), 64'd1);
      chk("res_kept", 64'(bus.res), 64'(e.res));
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
      #2;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_res", 64'(bus.res), 64'd0);
      chk("rst_cmp", 64'(bus.cmp), 64'd0);
      chk("rst_carry", 64'(bus.carry), 64'd0);
      chk("rst_err", 64'(bus.err), 64'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("in_ready_pre_edge", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      chk("in_ready_post_edge", 64'(bus.in_ready), 64'd1);

      run(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0);
      run(3'b001, 32'h8000_0001, 32'hDEAD_BEEF, 0, 1'b0);
      run(3'b010, 32'hF0F0_000F, 32'h0, 0, 1'b0);
      run(3'b011, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1'b0);
      run(3'b011, 32'h1234_5678, 32'h1234_5678, 0, 1'b0);
      run(3'b011, 32'h0000_0001, 32'h0000_0002, 0, 1'b0);
      run(3'b011, 32'h00AB_0000, 32'h00AC_0000, 0, 1'b1);
      run(3'b100, 32'd5, 32'd7, 0, 1'b0);
      run(3'b111, 32'h1234_5678, 32'h1, 0, 1'b0);
      run(3'b001, 32'h0000_0100, 32'h0, 0, 1'b0);
      run(3'b000, 32'h0000_FFFF, 32'h0000_0001, 3, 1'b0);
      run(3'b000, $urandom, $urandom, 0, 1'b0);
      run(3'b010, $urandom, 32'h0, 0, 1'b1);

      // abort an ADD mid-RUN with reset
      bus.in_valid = 1'b1; bus.op = 3'b000; bus.a = 32'h1111_1111; bus.b = 32'h2222_2222;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
      chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
      chk("abort_res", 64'(bus.res), 64'd0);
      chk("abort_cmp", 64'(bus.cmp), 64'd0);
      chk("abort_carry", 64'(bus.carry), 64'd0);
      chk("abort_err", 64'(bus.err), 64'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_valid", 64'(bus.out_valid), 64'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_abort_no_valid", 64'(bus.out_valid), 64'd0);
      end
      run(3'b000, 32'd3, 32'd4, 0, 1'b0);
      chk("add_3_4", 64'(bus.res), 64'd7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
